// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the request legality check used at acceptance.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   // True for a misaligned halfword/word or for the reserved size code.
   function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = offset[0];
         SZ_WORD: bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: extracts and extends load data from
// a memory word and merges sub-word store data into a read-back word.
module lsu_align
   import lsu_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [1:0]  byte_lane;
   logic [1:0]  half_lane;
   logic [31:0] byte_shift;
   logic [31:0] half_shift;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // half_lane is the lower of the two byte lanes a halfword occupies.
   always_comb begin
      byte_lane = BIG_ENDIAN ? (2'd3 - offset) : offset;
      half_lane = BIG_ENDIAN ? (2'd2 - {offset[1], 1'b0}) : {offset[1], 1'b0};
   end

   assign byte_shift = word >> {byte_lane, 3'b000};
   assign half_shift = word >> {half_lane, 3'b000};
   assign byte_val   = byte_shift[7:0];
   assign half_val   = half_shift[15:0];

   always_comb begin
      load_data = word;
      case (size)
         SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
         SZ_HALF: load_data = is_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
         default: load_data = word;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic [7:0] merged;

         always_comb begin
            merged = word[8*gi +: 8];
            case (size)
               SZ_BYTE: begin
                  if (byte_lane == LANE) merged = store_data[7:0];
               end
               SZ_HALF: begin
                  if (half_lane == LANE)              merged = store_data[7:0];
                  else if ((half_lane + 2'd1) == LANE) merged = store_data[15:8];
               end
               SZ_WORD: merged = store_data[8*gi +: 8];
               default: merged = word[8*gi +: 8];
            endcase
         end

         assign store_word[8*gi +: 8] = merged;
      end
   endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator for a word-addressed data memory; sub-word
// stores are done as read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        mem_read,
   output logic        mem_write
);

   state_t      state_reg;
   state_t      state_next;
   logic        write_reg;
   logic        unsigned_reg;
   logic        err_reg;
   logic [1:0]  size_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [31:0] buf_reg;
   logic        accept;
   logic        bad;
   logic [31:0] load_data;
   logic [31:0] store_word;

   assign accept = req_valid && (state_reg == IDLE);
   assign bad    = is_bad_req(req_size, req_addr[1:0]);

   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         write_reg    <= 1'b0;
         unsigned_reg <= 1'b0;
         err_reg      <= 1'b0;
         size_reg     <= SZ_BYTE;
         addr_reg     <= 32'h0;
         wdata_reg    <= 32'h0;
         buf_reg      <= 32'h0;
      end else begin
         if (accept) begin
            write_reg    <= req_write;
            unsigned_reg <= req_unsigned;
            err_reg      <= bad;
            size_reg     <= req_size;
            addr_reg     <= req_addr;
            wdata_reg    <= req_wdata;
         end
         if (state_reg == RD) buf_reg <= mem_rdata;
      end
   end

   lsu_align #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_align (
      .word        (buf_reg),
      .offset      (addr_reg[1:0]),
      .size        (size_reg),
      .is_unsigned (unsigned_reg),
      .store_data  (wdata_reg),
      .load_data   (load_data),
      .store_word  (store_word)
   );

   // Enables are gated by rst_n so a reset landing in WR cancels the negedge commit.
   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'h0;
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (bad)                                   state_next = RESP;
               else if (req_write && req_size == SZ_WORD) state_next = WR;
               else                                       state_next = RD;
            end
         end
         RD: begin
            mem_read   = rst_n;
            mem_addr   = {addr_reg[31:2], 2'b00};
            state_next = write_reg ? WR : RESP;
         end
         WR: begin
            mem_write  = rst_n;
            mem_addr   = {addr_reg[31:2], 2'b00};
            mem_wdata  = store_word;
            state_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_reg;
            if (!err_reg && !write_reg) resp_rdata = load_data;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, a reset-in-WR
// sequence, and randomized traffic against a byte-array memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_read;
   logic        mem_write;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   load_store_unit #(
      .BIG_ENDIAN (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_read     (mem_read),
      .mem_write    (mem_write)
   );

   // Word memory seen by the DUT, plus a byte-granular model in MIPS order.
   logic [31:0] mem_w [16];
   logic [7:0]  mb [64];
   logic        pre_en = 1'b0;
   logic [3:0]  pre_idx = 4'h0;
   logic [31:0] pre_val = 32'h0;

   assign mem_rdata = mem_w[mem_addr[5:2]];

   always @(negedge clk) begin
      if (pre_en)         mem_w[pre_idx] <= pre_val;
      else if (mem_write) mem_w[mem_addr[5:2]] <= mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input int k);
      return {mb[4*k], mb[4*k+1], mb[4*k+2], mb[4*k+3]};
   endfunction

   function automatic logic bad_m(input logic [1:0] size, input int a);
      return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [31:0] load_m(input logic [1:0] size, input logic uns, input int a);
      int v;
      case (size)
         2'd0: begin
            v = int'(mb[a]);
            if (!uns && v >= 128) v -= 256;
         end
         2'd1: begin
            v = int'(mb[a]) * 256 + int'(mb[a+1]);
            if (!uns && v >= 32768) v -= 65536;
         end
         default: v = int'({mb[a], mb[a+1], mb[a+2], mb[a+3]});
      endcase
      return 32'(v);
   endfunction

   task automatic store_m(input logic [1:0] size, input int a, input logic [31:0] d);
      case (size)
         2'd0: mb[a] = d[7:0];
         2'd1: begin
            mb[a]   = d[15:8];
            mb[a+1] = d[7:0];
         end
         default: begin
            mb[a]   = d[31:24];
            mb[a+1] = d[23:16];
            mb[a+2] = d[15:8];
            mb[a+3] = d[7:0];
         end
      endcase
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic preload(input int k, input logic [31:0] v);
      pre_idx = 4'(k);
      pre_val = v;
      pre_en  = 1'b1;
      @(negedge clk);
      #1;
      pre_en = 1'b0;
      mb[4*k]   = v[31:24];
      mb[4*k+1] = v[23:16];
      mb[4*k+2] = v[15:8];
      mb[4*k+3] = v[7:0];
      @(posedge clk);
      #1;
   endtask

   // Issues one request; fields are scrambled after acceptance to prove latching.
   task automatic do_req(input logic w, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int nrd, output int nwr);
      check("ready_idle", 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_write    = w;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_write    = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      lat = 1;
      nrd = 0;
      nwr = 0;
      while (!resp_valid && lat < 8) begin
         nrd += int'(mem_read);
         nwr += int'(mem_write);
         req_valid = 1'($urandom);
         @(posedge clk);
         #1;
         lat++;
      end
      req_valid = 1'b0;
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      rdata = resp_rdata;
      err   = resp_err;
      @(posedge clk);
      #1;
      check("resp_one_cycle", 32'(resp_valid), 32'd0);
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pre;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t        tbl[14];
   logic        w;
   logic        uns;
   logic        err;
   logic        exp_bad;
   logic [1:0]  sz;
   logic [31:0] d;
   logic [31:0] rdata;
   logic [31:0] exp_rd;
   int          a;
   int          lat;
   int          nrd;
   int          nwr;
   int          exp_lat;
   int          idx;

   initial begin
      tbl[0]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'h11223344, 32'h00000022, 1'b0, 2, 32'h11223344};
      tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'h80FF7F01, 32'hFFFFFFFF, 1'b0, 2, 32'h80FF7F01};
      tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h12, 32'h0,        32'h80FF7F01, 32'h0000007F, 1'b0, 2, 32'h80FF7F01};
      tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h80FF7F01, 32'hFFFFFF80, 1'b0, 2, 32'h80FF7F01};
      tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h80FF7F01, 32'hFFFF80FF, 1'b0, 2, 32'h80FF7F01};
      tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h80FF7F01, 32'h000080FF, 1'b0, 2, 32'h80FF7F01};
      tbl[6]  = '{1'b0, 2'd2, 1'b1, 32'h10, 32'h0,        32'h80FF7F01, 32'h80FF7F01, 1'b0, 2, 32'h80FF7F01};
      tbl[7]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 32'h11223344, 32'h00000000, 1'b0, 3, 32'h112233AB};
      tbl[8]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 32'h11223344, 32'h00000000, 1'b0, 3, 32'h1122BEEF};
      tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h14, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0, 2, 32'hDEADBEEF};
      tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        32'h11223344, 32'h00000000, 1'b1, 1, 32'h11223344};
      tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h16, 32'hCAFEF00D, 32'h55667788, 32'h00000000, 1'b1, 1, 32'h55667788};
      tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h11223344, 32'h00000000, 1'b1, 1, 32'h11223344};
      tbl[13] = '{1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, 32'h11223344, 32'h00000000, 1'b1, 1, 32'h11223344};

      // Reset, with memory seeded meanwhile.
      @(posedge clk);
      #1;
      for (int k = 0; k < 16; k++) preload(k, $urandom);
      check("rst_ready",      32'(req_ready),  32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_mem_read",   32'(mem_read),   32'd0);
      check("rst_mem_write",  32'(mem_write),  32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_ready",      32'(req_ready),  32'd1);
      check("idle_resp_valid", 32'(resp_valid), 32'd0);
      check("idle_resp_rdata", resp_rdata,      32'd0);
      check("idle_mem_addr",   mem_addr,        32'd0);

      // Directed vectors.
      for (int i = 0; i < 14; i++) begin
         idx = int'(tbl[i].addr[5:2]);
         preload(idx, tbl[i].pre);
         do_req(tbl[i].w, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rdata, err, lat, nrd, nwr);
         check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
         check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
         check($sformatf("vec%0d_reads", i), 32'(nrd),
               (tbl[i].exp_err || (tbl[i].w && tbl[i].size == 2'd2)) ? 32'd0 : 32'd1);
         check($sformatf("vec%0d_writes", i), 32'(nwr), (!tbl[i].exp_err && tbl[i].w) ? 32'd1 : 32'd0);
         check($sformatf("vec%0d_mem", i), mem_w[idx], tbl[i].exp_mem);
         $display("[TB] vec%0d w=%0d sz=%0d addr=%08h rdata=%08h err=%0d lat=%0d mem=%08h",
                  i, tbl[i].w, tbl[i].size, tbl[i].addr, rdata, err, lat, mem_w[idx]);
      end

      // Reset asserted during the WR cycle of an sb must cancel the write.
      preload(4, 32'h11223344);
      check("rstwr_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 2'd0;
      req_unsigned = 1'b0;
      req_addr  = 32'h13;
      req_wdata = 32'h000000AB;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rstwr_rd_phase", 32'(mem_read), 32'd1);
      @(posedge clk);
      #1;
      check("rstwr_wr_phase", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstwr_write_forced_off", 32'(mem_write), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rstwr_no_resp", 32'(resp_valid), 32'd0);
      check("rstwr_ready_after", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      check("rstwr_no_resp_later", 32'(resp_valid), 32'd0);
      check("rstwr_mem", mem_w[4], 32'h11223344);
      $display("[TB] reset-in-WR sb addr=00000013 mem=%08h", mem_w[4]);

      // Randomized traffic against the byte model.
      for (int k = 0; k < 16; k++) preload(k, $urandom);
      for (int t = 0; t < 150; t++) begin
         w   = 1'($urandom);
         uns = 1'($urandom);
         sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a   = int'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) a = a - (a % ((sz == 2'd1) ? 2 : 4));
         d   = $urandom;
         exp_bad = bad_m(sz, a);
         exp_rd  = 32'h0;
         if (!exp_bad && !w) exp_rd = load_m(sz, uns, a);
         exp_lat = exp_bad ? 1 : ((w && sz != 2'd2) ? 3 : 2);
         do_req(w, sz, uns, 32'(a), d, rdata, err, lat, nrd, nwr);
         if (!exp_bad && w) store_m(sz, a, d);
         check($sformatf("rnd%0d_rdata", t), rdata, exp_rd);
         check($sformatf("rnd%0d_err", t), 32'(err), 32'(exp_bad));
         check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(exp_lat));
         check($sformatf("rnd%0d_reads", t), 32'(nrd), (exp_bad || (w && sz == 2'd2)) ? 32'd0 : 32'd1);
         check($sformatf("rnd%0d_writes", t), 32'(nwr), (!exp_bad && w) ? 32'd1 : 32'd0);
         check($sformatf("rnd%0d_mem", t), mem_w[a / 4], model_word(a / 4));
         $display("[TB] rnd%0d w=%0d sz=%0d uns=%0d addr=%08h wdata=%08h rdata=%08h err=%0d lat=%0d",
                  t, w, sz, uns, a, d, rdata, err, lat);
      end

      for (int k = 0; k < 16; k++) check($sformatf("final_mem%0d", k), mem_w[k], model_word(k));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle initiator that drives the word-addressed data memory's memread/memwrite interface on behalf of the CPU datapath. Supports MIPS lb/lbu/lh/lhu/lw/sb/sh/sw. Sub-word stores use read-modify-write because the memory only writes whole words. Sits between the EX stage / multi-cycle control and the data memory, and exposes a valid/ready request port plus a one-cycle response pulse.

Parameters:
BIG_ENDIAN, 1, byte lane order; 1 = MIPS big-endian (offset 0 -> bits [31:24]), 0 = little-endian (offset 0 -> bits [7:0]).

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  reset, synchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  unit idle; a request is accepted on a posedge where req_valid && req_ready.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_err  out  1  valid with resp_valid; misaligned or illegal size.
resp_rdata  out  32  extended load data; 0 for stores and errors.
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
mem_wdata  out  32  merged word to write.
mem_rdata  in  32  memory read data (combinational from memory).
mem_read  out  1  memory read enable.
mem_write  out  1  memory write enable; memory commits on negedge clk while high.

Behaviour:
- Reset (rst_n low at posedge): state to IDLE, latched request and read buffer cleared, resp_valid/resp_err/resp_rdata = 0. mem_read and mem_write are combinationally forced to 0 in any cycle where rst_n = 0, so a reset in a WR cycle suppresses that negedge write.
- All inputs are latched at acceptance. req_valid in any non-IDLE state is ignored.
- States:
  - IDLE: req_ready = 1, all mem_* enables 0. On accept:
    - misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or size 11 -> RESP, no memory access.
    - sw -> WR.
    - everything else -> RD.
  - RD: mem_read = 1, mem_addr driven. mem_rdata is captured into the word buffer at the posedge. Next state: WR for sb/sh, RESP for loads.
  - WR: mem_write = 1. mem_wdata is the buffer with the selected lane(s) replaced by req_wdata[7:0] or [15:0]; for sw it is req_wdata. Next state: RESP.
  - RESP: resp_valid = 1 for exactly one cycle, req_ready = 0. Next state: IDLE.
- Latency, counted in cycles after the accept edge until resp_valid is high:
  - error: 1 cycle.
  - load or sw: 2 cycles.
  - sb/sh: 3 cycles.
- Lane select: offset = addr[1:0]; for halfwords, offset = addr[1]*2.
  - Big-endian byte lane = 3 - offset; big-endian halfword at offset 0 = bits [31:16].
- Extension: sign-extend from bit 7 or bit 15 unless req_unsigned. Word loads ignore req_unsigned.
- mem_addr holds the latched aligned address in RD and WR, and 0 otherwise.
- No overlapping requests. Back-to-back throughput is one request per (latency + 1) cycles.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - the state enum IDLE / RD / WR / RESP.
  - a function computing the misalignment flag.
- One natural combinational sub-module, lsu_align. Inputs: word, offset, size, unsigned, store data, BIG_ENDIAN. Outputs: extracted/extended load data and the merged store word. The FSM and registers stay in load_store_unit.

Test Plan:
1. Memory[0x10] = 0x11223344; lbu addr 0x11 -> mem_read high for one cycle, resp_valid 2 cycles after accept, resp_rdata = 0x00000022, mem_write never asserted.
2. Memory[0x10] = 0x80FF7F01:
   - lb 0x11 -> 0xFFFFFFFF; lb 0x12 -> 0x0000007F.
   - lh 0x10 -> 0xFFFF80FF; lhu 0x10 -> 0x000080FF.
   - lw 0x10 -> 0x80FF7F01.
3. Memory[0x10] = 0x11223344; sb 0x13 data 0x000000AB -> states RD, WR, RESP; memory = 0x112233AB; resp_rdata = 0.
4. sh 0x12 data 0x0000BEEF over 0x11223344 -> 0x1122BEEF. sw 0x14 data 0xDEADBEEF -> no mem_read, memory[0x14] = 0xDEADBEEF, resp_valid 2 cycles after accept.
5. lh 0x11, sw 0x16, and size 11 -> resp_err = 1 one cycle after accept; mem_read/mem_write stay 0; memory unchanged.
6. sb 0x13 with rst_n pulled low during the WR cycle -> memory stays 0x11223344, no resp_valid, req_ready = 1 in the cycle after reset releases.
